// File: rtl/uart_receive_if.sv
// rtl/uart_receive_if.sv - consumer-side handshake bundle of the UART receiver
//
// Carries the received word, its valid/ready handshake, the one-cycle error
// pulses and the busy indication between the receiver and its consumer.
//   rx_data      : last received word
//   rx_valid     : rx_data holds an unconsumed word
//   rx_ready     : consumer takes rx_data when high together with rx_valid
//   rx_frame_err : one-cycle pulse, stop bit sampled low
//   rx_overrun   : one-cycle pulse, word completed while the previous one was unconsumed
//   rx_busy      : receiver is inside a frame
// modport master : receiver side; modport slave : consumer side.
interface uart_receive_if #(
    parameter int D_WIDTH = 4
) ();
    logic [D_WIDTH-1:0] rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               rx_frame_err;
    logic               rx_overrun;
    logic               rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_overrun,
        output rx_busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_overrun,
        input  rx_busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - UART frame receiver with valid/ready output and error pulses
//
// Recovers start / D_WIDTH data bits (LSB first) / stop frames from an
// asynchronous serial line and hands each word to the consumer.
//   clk    : clock
//   rst    : synchronous, active-high reset
//   rx     : asynchronous serial input, idle high
//   out_if : word, handshake, framing-error / overrun pulses and busy (master side)
module uart_receive #(
    parameter int D_WIDTH      = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_receive_if.master out_if
);
    // Offset from the detected falling edge to the middle of a bit cell.
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW   = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

    localparam logic [TW-1:0] T_FULL    = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF_M1 = (HALF > 0) ? TW'(HALF - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST  = IW'(D_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q;
    logic               rx_s_q;
    logic [TW-1:0]      timer_q, timer_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [D_WIDTH-1:0] shift_q, shift_d;
    logic [D_WIDTH-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;
    logic [D_WIDTH:0]   shift_cat;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Bits arrive LSB first, so each new sample enters at the MSB and the
    // word is right-aligned once the last data bit is in.
    assign shift_cat = {rx_s_q, shift_q};

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && out_if.rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    // With one or two clocks per bit the detection edge is
                    // already mid-start-bit, so there is nothing to verify.
                    if (HALF == 0) begin
                        state_d = DATA;
                        timer_d = T_FULL;
                        idx_d   = '0;
                    end else begin
                        state_d = START;
                        timer_d = T_HALF_M1;
                    end
                end
            end
            START: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (!rx_s_q) begin
                    state_d = DATA;
                    timer_d = T_FULL;
                    idx_d   = '0;
                end else begin
                    // Line is back high at mid-start: treat as a glitch.
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    shift_d = shift_cat[D_WIDTH:1];
                    timer_d = T_FULL;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            STOP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (rx_s_q) begin
                    // A completion always loads the new word; it only counts as
                    // an overrun when the old word is not being taken this cycle.
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    ovr_d   = valid_q && !out_if.rx_ready;
                    state_d = IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // Holding here keeps a long break from reporting more than once.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_if.rx_data      = data_q;
    assign out_if.rx_valid     = valid_q;
    assign out_if.rx_frame_err = ferr_q;
    assign out_if.rx_overrun   = ovr_q;
    assign out_if.rx_busy      = (state_q != IDLE);
endmodule

// File: doc/uart_receive.md
# uart_receive

- Receive side of the team's UART link, paired with the existing one-bit-per-frame-slot transmitter.
- Frame format: start bit 0, D_WIDTH data bits LSB first, one stop bit 1.
- Recovers frames from the serial line, synchronizes the asynchronous input, and validates start and stop bits.
- Presents each byte on a valid/ready interface with framing-error and overrun reporting; sits between the pad-side serial input and the consuming logic.

## Interface

- D_WIDTH, 4, data bits per frame (≥1).
- CLKS_PER_BIT, 1, clk cycles per bit (≥1); 1 matches the transmitter's one bit per clock.
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- rx  input  1  asynchronous serial line, idle high.
- rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
- rx_data  output  D_WIDTH  last received word.
- rx_valid  output  1  rx_data holds an unconsumed word.
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- rx_overrun  output  1  one-cycle pulse: word completed while previous word unconsumed.
- rx_busy  output  1  high whenever FSM is not IDLE.

## Operation

- **Synchronizer.** rx passes through two flops (both reset to 1); the FSM uses only the second flop, rx_s.
- **Constants.**
  - HALF = (CLKS_PER_BIT-1)/2, integer divide.
  - Bit timer width = max(1, clog2(CLKS_PER_BIT)); bit index width = max(1, clog2(D_WIDTH)).
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. Bit timer counts down.
- **IDLE**, on rx_s==0:
  - HALF==0 → DATA, timer=CLKS_PER_BIT-1, idx=0.
  - else → START, timer=HALF-1.
- **START.**
  - timer≠0 → decrement.
  - timer==0 and rx_s==0 → DATA, timer=CLKS_PER_BIT-1, idx=0.
  - timer==0 and rx_s==1 → IDLE (false start, no flags).
- **DATA.**
  - timer≠0 → decrement.
  - timer==0 → shift rx_s into MSB of shift register (LSB-first assembly), timer=CLKS_PER_BIT-1.
  - Then idx==D_WIDTH-1 → STOP; else idx+1.
- **STOP.**
  - timer≠0 → decrement.
  - timer==0 and rx_s==1 → load rx_data from shift register, set rx_valid, → IDLE (hunt resumes next cycle; back-to-back frames supported).
  - timer==0 and rx_s==0 → pulse rx_frame_err, rx_data and rx_valid unchanged, → WAIT_HIGH.
- **WAIT_HIGH.** Stay until rx_s==1, then → IDLE (a held-low break yields exactly one error).
- **Handshake.**
  - rx_valid&rx_ready at an edge clears rx_valid.
  - Completion with rx_valid already high and rx_ready low: overwrite rx_data, rx_valid stays 1, pulse rx_overrun.
  - Completion in the same cycle as acceptance: new word loaded, rx_valid stays 1, no overrun.
- **Reset values.**
  - Sync flops 1, state IDLE, rx_data 0, rx_valid 0, rx_frame_err 0, rx_overrun 0, rx_busy 0.
  - Timer, index and shift register 0.
  - Reset mid-frame aborts the frame with no flags.

## Timing

- Start bit first captured by the sync flop 1 at edge k:
  - Detected at edge k+2.
  - Start verified at edge k+2+HALF.
  - Data bit i sampled at k+2+HALF+CLKS_PER_BIT·(i+1).
  - Stop sampled at k+2+HALF+CLKS_PER_BIT·(D_WIDTH+1).
- rx_valid, rx_data, rx_frame_err and rx_overrun update at the stop-sample edge.
- CLKS_PER_BIT=1, D_WIDTH=4: rx_valid high after edge k+7.
- rx_busy rises the cycle after detection and falls the cycle after the stop sample, or after WAIT_HIGH exit.
- rx_frame_err and rx_overrun are high for exactly one cycle per event.
- All outputs are registered, except rx_busy, which is decoded from the state register.

## Test plan

- **Basic frame.** CLKS_PER_BIT=1, D_WIDTH=4: drive rx 1,0,0,1,0,1,1 from edge k (0xA), rx_ready=1 → rx_data=0xA, rx_valid high for one cycle after edge k+7, no flags.
- **Loopback.** Connect the transmitter's tx to rx, send 0x0, 0xF, 0x5 back-to-back → three valid words in order, no errors.
- **Framing error.** CLKS_PER_BIT=4: frame 0x3 with stop bit 0, then 8 cycles low → exactly one rx_frame_err pulse, rx_valid stays 0; after the line goes high, the next frame 0x6 is received correctly.
- **Glitch rejection.** CLKS_PER_BIT=16: 3-cycle low glitch → returns to IDLE, no rx_valid, rx_busy pulses then clears.
- **Overrun / same-cycle accept.** rx_ready=0, frames 0x1 then 0x2 → rx_overrun pulse at the second completion, rx_data=0x2, rx_valid=1. Repeat with rx_ready=1 in the completion cycle → no overrun.
- **Reset mid-frame.** Assert rst after data bit 1 → all outputs return to reset values next cycle; a following frame 0x9 is received correctly.
